// File: rtl/gol_step_ctrl_pkg.sv
// Shared definitions for the Game of Life generation sequencer:
// neighbour slot count, controller states and the B3/S23 rule.
package gol_step_ctrl_pkg;

  localparam int unsigned NEIGHBOURS_CNT = 8;
  localparam int unsigned SELF_SLOT      = NEIGHBOURS_CNT;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } ctrl_state_t;

  function automatic logic life_rule(input logic self, input logic [3:0] cnt);
    return (cnt == 4'd3) || (self && (cnt == 4'd2));
  endfunction

endpackage

// File: rtl/gol_step_ctrl_nbrs.sv
// Neighbour address generator: coordinates and in-field flags of the eight
// neighbours of (x, y), slots numbered 0 1 2 / 3 x 4 / 5 6 7.
module get_nbrs_address
  import gol_step_ctrl_pkg::*;
#(
  parameter  int unsigned FIELD_W = 8,
  parameter  int unsigned FIELD_H = 8,
  localparam int unsigned XW      = $clog2(FIELD_W),
  localparam int unsigned YW      = $clog2(FIELD_H)
) (
  input  logic [XW-1:0]                     x,
  input  logic [YW-1:0]                     y,
  output logic [NEIGHBOURS_CNT-1:0][XW-1:0] nbr_x,
  output logic [NEIGHBOURS_CNT-1:0][YW-1:0] nbr_y,
  output logic [NEIGHBOURS_CNT-1:0]         nbr_valid
);

  logic [XW-1:0] xm, xp;
  logic [YW-1:0] ym, yp;
  logic          has_l, has_r, has_u, has_d;

  assign xm    = x - 1'b1;
  assign xp    = x + 1'b1;
  assign ym    = y - 1'b1;
  assign yp    = y + 1'b1;
  assign has_l = (x != '0);
  assign has_r = (x != XW'(FIELD_W - 1));
  assign has_u = (y != '0);
  assign has_d = (y != YW'(FIELD_H - 1));

  // Concatenations list slot 7 first, slot 0 last.
  assign nbr_x     = {xp, x, xm, xp, xm, xp, x, xm};
  assign nbr_y     = {yp, yp, yp, y, y, ym, ym, ym};
  assign nbr_valid = {has_r & has_d, has_d, has_l & has_d, has_r, has_l,
                      has_r & has_u, has_u, has_l & has_u};

endmodule

// File: rtl/gol_step_ctrl.sv
// One-generation Game of Life sequencer: 9 read slots + 1 write per cell.
// Define GOL_TORUS_EN for a wrapping field; otherwise edge neighbours count as dead.
module gol_step_ctrl
  import gol_step_ctrl_pkg::*;
#(
  parameter  int unsigned FIELD_W = 8,
  parameter  int unsigned FIELD_H = 8,
  localparam int unsigned XW      = $clog2(FIELD_W),
  localparam int unsigned YW      = $clog2(FIELD_H)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_rd_en,
  output logic [XW-1:0] o_rd_x_adr,
  output logic [YW-1:0] o_rd_y_adr,
  input  logic          i_rd_data,
  output logic          o_wr_en,
  output logic [XW-1:0] o_wr_x_adr,
  output logic [YW-1:0] o_wr_y_adr,
  output logic          o_wr_data
);

  ctrl_state_t   state, state_nx;
  logic [3:0]    slot, slot_nx;
  logic [XW-1:0] cell_x, x_nx;
  logic [YW-1:0] cell_y, y_nx;
  logic [3:0]    cnt, cnt_nx;
  logic          acc_pend, pend_nx;

  logic [NEIGHBOURS_CNT-1:0][XW-1:0] gen_x, nx;
  logic [NEIGHBOURS_CNT-1:0][YW-1:0] gen_y, ny;
  logic [NEIGHBOURS_CNT-1:0]         gen_valid, nv;

  logic          slot_is_self, sel_valid, last_cell;
  logic [XW-1:0] sel_x;
  logic [YW-1:0] sel_y;

  get_nbrs_address #(
    .FIELD_W (FIELD_W),
    .FIELD_H (FIELD_H)
  ) u_nbrs (
    .x         (cell_x),
    .y         (cell_y),
    .nbr_x     (gen_x),
    .nbr_y     (gen_y),
    .nbr_valid (gen_valid)
  );

`ifdef GOL_TORUS_EN
  // Explicit wrap compare keeps non-power-of-two field sizes correct.
  logic [XW-1:0] txm, txp;
  logic [YW-1:0] tym, typ;
  assign txm = (cell_x == '0) ? XW'(FIELD_W - 1) : cell_x - 1'b1;
  assign txp = (cell_x == XW'(FIELD_W - 1)) ? '0 : cell_x + 1'b1;
  assign tym = (cell_y == '0) ? YW'(FIELD_H - 1) : cell_y - 1'b1;
  assign typ = (cell_y == YW'(FIELD_H - 1)) ? '0 : cell_y + 1'b1;
  assign nx  = {txp, cell_x, txm, txp, txm, txp, cell_x, txm};
  assign ny  = {typ, typ, typ, cell_y, cell_y, tym, tym, tym};
  assign nv  = '1;
`else
  assign nx  = gen_x;
  assign ny  = gen_y;
  assign nv  = gen_valid;
`endif

  assign slot_is_self = (slot == 4'(SELF_SLOT));
  assign sel_valid    = slot_is_self ? 1'b1   : nv[slot[2:0]];
  assign sel_x        = slot_is_self ? cell_x : nx[slot[2:0]];
  assign sel_y        = slot_is_self ? cell_y : ny[slot[2:0]];
  assign last_cell    = (cell_x == XW'(FIELD_W - 1)) && (cell_y == YW'(FIELD_H - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      slot     <= '0;
      cell_x   <= '0;
      cell_y   <= '0;
      cnt      <= '0;
      acc_pend <= 1'b0;
    end else begin
      state    <= state_nx;
      slot     <= slot_nx;
      cell_x   <= x_nx;
      cell_y   <= y_nx;
      cnt      <= cnt_nx;
      acc_pend <= pend_nx;
    end
  end

  always_comb begin
    state_nx = state;
    slot_nx  = slot;
    x_nx     = cell_x;
    y_nx     = cell_y;
    cnt_nx   = acc_pend ? cnt + {3'b000, i_rd_data} : cnt;
    pend_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_start) begin
          state_nx = READ;
          slot_nx  = '0;
          x_nx     = '0;
          y_nx     = '0;
          cnt_nx   = '0;
        end
      end
      READ: begin
        // Data for this slot arrives next cycle; remember whether to add it.
        pend_nx = o_rd_en && !slot_is_self;
        if (slot_is_self) state_nx = WRITE;
        else              slot_nx  = slot + 4'd1;
      end
      WRITE: begin
        slot_nx = '0;
        cnt_nx  = '0;
        if (last_cell) begin
          state_nx = DONE;
          x_nx     = '0;
          y_nx     = '0;
        end else begin
          state_nx = READ;
          if (cell_x == XW'(FIELD_W - 1)) begin
            x_nx = '0;
            y_nx = cell_y + 1'b1;
          end else begin
            x_nx = cell_x + 1'b1;
          end
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    o_busy     = (state != IDLE);
    o_done     = (state == DONE);
    o_rd_en    = (state == READ) && sel_valid;
    o_rd_x_adr = o_rd_en ? sel_x : '0;
    o_rd_y_adr = o_rd_en ? sel_y : '0;
    o_wr_en    = (state == WRITE);
    o_wr_x_adr = o_wr_en ? cell_x : '0;
    o_wr_y_adr = o_wr_en ? cell_y : '0;
    o_wr_data  = o_wr_en && life_rule(i_rd_data, cnt);
  end

endmodule

// File: tb/tb_gol_step_ctrl.sv
// Directed bench for gol_step_ctrl on 5x5, 4x4 and 5x3 fields with simple
// field memories; expectations follow GOL_TORUS_EN when it is defined.
module tb_gol_step_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

`ifdef GOL_TORUS_EN
  localparam logic [8:0]  CORNER_SLOTS = 9'h1FF;
  localparam int          X4_READS     = 3;
  localparam logic [14:0] C_NEXT       = 15'h0421;
`else
  localparam logic [8:0]  CORNER_SLOTS = 9'h1D0;
  localparam int          X4_READS     = 0;
  localparam logic [14:0] C_NEXT       = 15'h0000;
`endif

  // DUT A: 5x5
  logic start_a = 1'b0, busy_a, done_a, rd_en_a, wr_en_a, wr_data_a;
  logic rd_data_a = 1'b0;
  logic [2:0] rd_x_a, rd_y_a, wr_x_a, wr_y_a;
  logic [24:0] cur_a = '0, nxt_a = '0;
  int wr_cnt_a = 0, done_cnt_a = 0;

  // DUT B: 4x4
  logic start_b = 1'b0, busy_b, done_b, rd_en_b, wr_en_b, wr_data_b;
  logic rd_data_b = 1'b0;
  logic [1:0] rd_x_b, rd_y_b, wr_x_b, wr_y_b;
  logic [15:0] cur_b = '0, nxt_b = '0;
  int wr_cnt_b = 0, done_cnt_b = 0;

  // DUT C: 5x3
  logic start_c = 1'b0, busy_c, done_c, rd_en_c, wr_en_c, wr_data_c;
  logic rd_data_c = 1'b0;
  logic [2:0] rd_x_c, wr_x_c;
  logic [1:0] rd_y_c, wr_y_c;
  logic [14:0] cur_c = '0, nxt_c = '0;
  int wr_cnt_c = 0, done_cnt_c = 0;

  gol_step_ctrl #(.FIELD_W(5), .FIELD_H(5)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(start_a), .o_busy(busy_a), .o_done(done_a),
    .o_rd_en(rd_en_a), .o_rd_x_adr(rd_x_a), .o_rd_y_adr(rd_y_a), .i_rd_data(rd_data_a),
    .o_wr_en(wr_en_a), .o_wr_x_adr(wr_x_a), .o_wr_y_adr(wr_y_a), .o_wr_data(wr_data_a));

  gol_step_ctrl #(.FIELD_W(4), .FIELD_H(4)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(start_b), .o_busy(busy_b), .o_done(done_b),
    .o_rd_en(rd_en_b), .o_rd_x_adr(rd_x_b), .o_rd_y_adr(rd_y_b), .i_rd_data(rd_data_b),
    .o_wr_en(wr_en_b), .o_wr_x_adr(wr_x_b), .o_wr_y_adr(wr_y_b), .o_wr_data(wr_data_b));

  gol_step_ctrl #(.FIELD_W(5), .FIELD_H(3)) u_dut_c (
    .i_clk(clk), .i_rst(rst), .i_start(start_c), .o_busy(busy_c), .o_done(done_c),
    .o_rd_en(rd_en_c), .o_rd_x_adr(rd_x_c), .o_rd_y_adr(rd_y_c), .i_rd_data(rd_data_c),
    .o_wr_en(wr_en_c), .o_wr_x_adr(wr_x_c), .o_wr_y_adr(wr_y_c), .o_wr_data(wr_data_c));

  // Field memories: unread cycles return 1 so a stray accumulate shows up.
  always @(posedge clk) begin
    rd_data_a <= rd_en_a ? cur_a[5'(rd_y_a) * 5'd5 + 5'(rd_x_a)] : 1'b1;
    if (clr) nxt_a <= '1;
    else if (wr_en_a) nxt_a[5'(wr_y_a) * 5'd5 + 5'(wr_x_a)] <= wr_data_a;
    if (wr_en_a) wr_cnt_a <= wr_cnt_a + 1;
    if (done_a) done_cnt_a <= done_cnt_a + 1;

    rd_data_b <= rd_en_b ? cur_b[{rd_y_b, rd_x_b}] : 1'b1;
    if (clr) nxt_b <= '1;
    else if (wr_en_b) nxt_b[{wr_y_b, wr_x_b}] <= wr_data_b;
    if (wr_en_b) wr_cnt_b <= wr_cnt_b + 1;
    if (done_b) done_cnt_b <= done_cnt_b + 1;

    rd_data_c <= rd_en_c ? cur_c[4'(rd_y_c) * 4'd5 + 4'(rd_x_c)] : 1'b1;
    if (clr) nxt_c <= '1;
    else if (wr_en_c) nxt_c[4'(wr_y_c) * 4'd5 + 4'(wr_x_c)] <= wr_data_c;
    if (wr_en_c) wr_cnt_c <= wr_cnt_c + 1;
    if (done_c) done_cnt_c <= done_cnt_c + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // {busy, done, rd_en, wr_en, wr_data, rd_x[2:0], rd_y[2:0], wr_x[2:0], wr_y[2:0]}
  function automatic logic [16:0] outs(input int which);
    case (which)
      0:       return {busy_a, done_a, rd_en_a, wr_en_a, wr_data_a,
                       rd_x_a, rd_y_a, wr_x_a, wr_y_a};
      1:       return {busy_b, done_b, rd_en_b, wr_en_b, wr_data_b,
                       1'b0, rd_x_b, 1'b0, rd_y_b, 1'b0, wr_x_b, 1'b0, wr_y_b};
      default: return {busy_c, done_c, rd_en_c, wr_en_c, wr_data_c,
                       rd_x_c, 1'b0, rd_y_c, wr_x_c, 1'b0, wr_y_c};
    endcase
  endfunction

  task automatic set_start(input int which, input logic v);
    case (which)
      0:       start_a = v;
      1:       start_b = v;
      default: start_c = v;
    endcase
  endtask

  logic [8:0]  slot_en;
  logic [16:0] wr10;
  int          x4_reads;

  // Pulses start, then samples every cycle (n = 1 is READ slot 0 of cell (0,0)).
  // Returns the cycle index of o_done, 0 on timeout, or -1 after a planted reset.
  task automatic run(input int which, input int start_again_at, input int rst_at,
                     output int done_n);
    logic [16:0] o;
    done_n   = 0;
    slot_en  = '0;
    wr10     = '0;
    x4_reads = 0;
    @(negedge clk);
    set_start(which, 1'b1);
    clr = 1'b1;
    @(posedge clk);
    #1;
    set_start(which, 1'b0);
    clr = 1'b0;
    for (int n = 1; n <= 400; n++) begin
      o = outs(which);
      if (n == 1) check("busy_first", 32'(o[16]), 32'd1);
      if (n <= 9) begin
        slot_en[n-1] = o[14];
        if (o[14] && (o[11:9] == 3'd4)) x4_reads++;
      end
      if (n == 10) wr10 = o;
      set_start(which, n == start_again_at);
      if (n == rst_at) begin
        check("wr_before_rst", 32'(o[13]), 32'd1);
        rst = 1'b1;
        #1;
        check("outs_in_rst", 32'(outs(which)), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_n = -1;
        break;
      end
      if (o[15]) begin
        done_n = n;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int dn, wr0, d0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outs_a", 32'(outs(0)), 32'd0);
    check("rst_outs_b", 32'(outs(1)), 32'd0);
    check("rst_outs_c", 32'(outs(2)), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_outs_a", 32'(outs(0)), 32'd0);

    // Blinker on 5x5: horizontal bar turns vertical
    cur_a = 25'h0003800;
    wr0 = wr_cnt_a; d0 = done_cnt_a;
    run(0, 0, 0, dn);
    check("blinker_done_cyc", 32'(dn), 32'd251);
    @(posedge clk); #1;
    check("blinker_field", 32'(nxt_a), 32'h0021080);
    check("blinker_writes", 32'(wr_cnt_a - wr0), 32'd25);
    check("blinker_dones", 32'(done_cnt_a - d0), 32'd1);
    check("blinker_idle", 32'(busy_a), 32'd0);

    // Corner on 4x4: (1,1) is born; edge slots of cell (0,0) are not read
    cur_b = 16'h0013;
    run(1, 0, 0, dn);
    check("corner_done_cyc", 32'(dn), 32'd161);
    check("corner_slot_rd", 32'(slot_en), 32'(CORNER_SLOTS));
    check("corner_wr00", 32'({wr10[13], wr10[12], wr10[5:0]}), 32'h0C0);
    @(posedge clk); #1;
    check("corner_field", 32'(nxt_b), 32'h0033);

    // Block still life on 4x4
    cur_b = 16'h0660;
    wr0 = wr_cnt_b;
    run(1, 0, 0, dn);
    check("block_done_cyc", 32'(dn), 32'd161);
    @(posedge clk); #1;
    check("block_field", 32'(nxt_b), 32'h0660);
    check("block_writes", 32'(wr_cnt_b - wr0), 32'd16);

    // Wrap pattern on 5x3
    cur_c = 15'h0013;
    run(2, 0, 0, dn);
    check("c_done_cyc", 32'(dn), 32'd151);
    check("c_x4_reads", 32'(x4_reads), 32'(X4_READS));
    @(posedge clk); #1;
    check("c_field", 32'(nxt_c), 32'(C_NEXT));

    // Second start during READ of cell 3 is ignored
    cur_a = 25'h0003800;
    d0 = done_cnt_a;
    run(0, 33, 0, dn);
    check("restart_done_cyc", 32'(dn), 32'd251);
    repeat (20) @(posedge clk);
    #1;
    check("restart_dones", 32'(done_cnt_a - d0), 32'd1);
    check("restart_idle", 32'(busy_a), 32'd0);
    check("restart_field", 32'(nxt_a), 32'h0021080);

    // Reset during WRITE of cell 5, then a clean rerun
    run(0, 0, 60, dn);
    wr0 = wr_cnt_a;
    repeat (30) @(posedge clk);
    #1;
    check("post_rst_writes", 32'(wr_cnt_a - wr0), 32'd0);
    check("post_rst_busy", 32'(busy_a), 32'd0);
    run(0, 0, 0, dn);
    check("rerun_done_cyc", 32'(dn), 32'd251);
    @(posedge clk); #1;
    check("rerun_field", 32'(nxt_a), 32'h0021080);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
